// File: rtl/instr_rom.sv
// instr_rom
// Read-only instruction memory for the fetch stage. The program lives in a
// constant table inside this file; the word at word address PCF is returned
// on InstrF one clock after it is presented.
//
// Ports:
//   clk     system clock, all state updates on the rising edge
//   reset   synchronous, active-high; clears InstrF on the edge it is seen
//   PCF     word address (index, not byte address) of the instruction
//   InstrF  registered instruction word, BITS_DATA wide
module instr_rom #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITS_ADDR-1:0] PCF,
    output logic [BITS_DATA-1:0] InstrF
);

    // Program content. Editing the program means editing only this table;
    // any address past the last entry reads as zero.
    localparam int PROG_LEN = 21;
    localparam logic [31:0] PROGRAM [PROG_LEN] = '{
        32'h00500113,  //  0
        32'h00C00193,  //  1
        32'hFF718393,  //  2
        32'h0023E233,  //  3
        32'h0041F2B3,  //  4
        32'h004282B3,  //  5
        32'h02728863,  //  6
        32'h0041A233,  //  7
        32'h00020463,  //  8
        32'h00000293,  //  9
        32'h0023A233,  // 10
        32'h005203B3,  // 11
        32'h402383B3,  // 12
        32'h0471AA23,  // 13
        32'h06002103,  // 14
        32'h005104B3,  // 15
        32'h008001EF,  // 16
        32'h00100113,  // 17
        32'h00910133,  // 18
        32'h0221A023,  // 19
        32'h00210063   // 20
    };

    logic [31:0]          word_raw;
    logic [BITS_DATA-1:0] instr_d;
    logic [BITS_DATA-1:0] instr_q;

    // Table lookup written as a compare loop so the address width and the
    // table length can differ without an out-of-bounds index.
    always_comb begin
        word_raw = 32'h0000_0000;
        for (int i = 0; i < PROG_LEN; i++) begin
            if (int'(PCF) == i) begin
                word_raw = PROGRAM[i];
            end
        end
        // Size cast zero-extends for wider words and keeps the LSBs for
        // narrower ones.
        instr_d = BITS_DATA'(word_raw);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
        end else begin
            instr_q <= instr_d;
        end
    end

    assign InstrF = instr_q;

endmodule

// File: tb/tb_instr_rom.sv
// tb_instr_rom
// Directed bench for instr_rom: reset, sequential fetch, top address,
// mid-cycle address change, mid-program reset and a full address sweep.
module tb_instr_rom;

    logic        clk;
    logic        reset;
    logic [4:0]  PCF;
    logic [31:0] InstrF;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_tbl [32];

    instr_rom #(
        .BITS_DATA(32),
        .BITS_ADDR(5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .PCF    (PCF),
        .InstrF (InstrF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_tbl[i] = 32'h0000_0000;
        exp_tbl[0]  = 32'h00500113;
        exp_tbl[1]  = 32'h00C00193;
        exp_tbl[2]  = 32'hFF718393;
        exp_tbl[3]  = 32'h0023E233;
        exp_tbl[4]  = 32'h0041F2B3;
        exp_tbl[5]  = 32'h004282B3;
        exp_tbl[6]  = 32'h02728863;
        exp_tbl[7]  = 32'h0041A233;
        exp_tbl[8]  = 32'h00020463;
        exp_tbl[9]  = 32'h00000293;
        exp_tbl[10] = 32'h0023A233;
        exp_tbl[11] = 32'h005203B3;
        exp_tbl[12] = 32'h402383B3;
        exp_tbl[13] = 32'h0471AA23;
        exp_tbl[14] = 32'h06002103;
        exp_tbl[15] = 32'h005104B3;
        exp_tbl[16] = 32'h008001EF;
        exp_tbl[17] = 32'h00100113;
        exp_tbl[18] = 32'h00910133;
        exp_tbl[19] = 32'h0221A023;
        exp_tbl[20] = 32'h00210063;

        // Reset held for two edges with a nonzero address presented.
        reset = 1'b1;
        PCF   = 5'd3;
        tick();
        check("reset_edge1", InstrF, 32'h0000_0000);
        tick();
        check("reset_edge2", InstrF, 32'h0000_0000);

        // Sequential fetch, one edge of latency each.
        reset = 1'b0;
        PCF = 5'd0; tick(); check("seq_pc0", InstrF, 32'h00500113);
        PCF = 5'd1; tick(); check("seq_pc1", InstrF, 32'h00C00193);
        PCF = 5'd2; tick(); check("seq_pc2", InstrF, 32'hFF718393);
        PCF = 5'd3; tick(); check("seq_pc3", InstrF, 32'h0023E233);

        // Highest address is a legal read of zero.
        PCF = 5'd31; tick(); check("top_addr", InstrF, 32'h0000_0000);

        // Mid-cycle address change must not reach the output early.
        PCF = 5'd4; tick(); check("mid_pc4", InstrF, 32'h0041F2B3);
        #3 PCF = 5'd5;
        #2 check("mid_hold", InstrF, 32'h0041F2B3);
        tick(); check("mid_pc5", InstrF, 32'h004282B3);

        // Reset in the middle of the program wins over the read.
        PCF   = 5'd6;
        reset = 1'b1;
        tick(); check("midrst_clear", InstrF, 32'h0000_0000);
        reset = 1'b0;
        tick(); check("midrst_resume", InstrF, 32'h02728863);

        // Full sweep, descending then ascending order.
        for (int i = 31; i >= 0; i--) begin
            PCF = 5'(i);
            tick();
            check($sformatf("sweep_dn_%0d", i), InstrF, exp_tbl[i]);
        end
        for (int i = 0; i < 32; i++) begin
            PCF = 5'(i);
            tick();
            check($sformatf("sweep_up_%0d", i), InstrF, exp_tbl[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_rom.md
Name: instr_rom

Overview:
- Read-only instruction memory for the fetch stage of the pipelined processor.
- Holds a fixed program of 2^BITS_ADDR words, indexed by word address PCF.
- Returns the instruction word on InstrF, registered with one-cycle latency.
- Contents are hard-coded in RTL as a constant table; no write port.

Parameters:
- BITS_DATA, 32, width of each instruction word and of InstrF.
- BITS_ADDR, 5, word-address width; depth = 2^BITS_ADDR words (32 by default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- PCF  input  BITS_ADDR  word address of the instruction to fetch (word index, not byte address).
- InstrF  output  BITS_DATA  instruction word read from address PCF.

Behaviour:
- One clock; reset is synchronous and active-high.
- Storage is a constant table of 2^BITS_ADDR entries, 32-bit program words:
  - If BITS_DATA > 32, words are zero-extended.
  - If BITS_DATA < 32, words are truncated to the LSBs.
- Read on each rising clk edge:
  - reset = 1: InstrF <= 0x00000000.
  - reset = 0: InstrF <= mem[PCF].
  - Latency is exactly 1 cycle from PCF change to InstrF update.
- Reset value of InstrF is 0x00000000.
  - From time 0 until the first clk edge with reset = 1, InstrF is unspecified (X allowed).
  - Benches apply reset first.
- Reset has priority over reading. A reset asserted mid-program clears InstrF on that edge. The first valid read is the edge after reset deasserts.
- PCF changes between edges have no effect until the next edge. No combinational path from PCF to InstrF.
- Every address 0..2^BITS_ADDR-1 is in range; there is no out-of-range condition or error output. The highest address (31 by default) is a legal read.
- No wrap or overflow logic; PCF is used directly as the index.
- Default program (addresses are word indices, values in hex):
  - 0: 00500113
  - 1: 00C00193
  - 2: FF718393
  - 3: 0023E233
  - 4: 0041F2B3
  - 5: 004282B3
  - 6: 02728863
  - 7: 0041A233
  - 8: 00020463
  - 9: 00000293
  - 10: 0023A233
  - 11: 005203B3
  - 12: 402383B3
  - 13: 0471AA23
  - 14: 06002103
  - 15: 005104B3
  - 16: 008001EF
  - 17: 00100113
  - 18: 00910133
  - 19: 0221A023
  - 20: 00210063
- Addresses 21..31 (and any address beyond the table for larger BITS_ADDR) read 0x00000000.
- The table is the single source of program content; changing the program means editing only this table.

Test Plan:
- Reset: reset = 1 for 2 edges with PCF = 3 -> InstrF = 0x00000000 after the first edge.
- Sequential fetch: reset = 0, PCF = 0, 1, 2, 3 on successive edges -> InstrF = 00500113, 00C00193, FF718393, 0023E233, each one edge after its PCF.
- Top address: PCF = 31 -> InstrF = 0x00000000 one edge later; no X, no error.
- Latency/stability: change PCF mid-cycle from 4 to 5 -> InstrF is unchanged until the next edge, then = 004282B3.
- Mid-operation reset: PCF = 6, assert reset for one edge -> InstrF = 0x00000000. After deassert, the next edge gives 02728863.
- Full sweep: PCF = 0..31 -> every InstrF matches the table; addresses 21..31 read 0x00000000.
